// File: rtl/mac_frame_pipe.sv
// Framed multiply-accumulate: a start-triggered frame of len samples is passed through a
// three-stage operand/product/accumulate pipeline, with an optional saturating accumulator.
module mac_frame_pipe #(
   parameter int DW   = 8,
   parameter int CW   = 6,
   parameter int ACCW = 20
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [CW-1:0]   len,
   input  logic            sat_en,
   input  logic            in_valid,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic            in_ready,
   output logic [2*DW-1:0] prod,
   output logic [ACCW-1:0] acc,
   output logic            out_valid,
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              drain_q, drain_d;
   logic              sat_q, sat_d;
   logic              clr_acc_s;
   logic              accept_s;
   logic [DW-1:0]     a_q, b_q;
   logic              v1_q, v2_q;
   logic [2*DW-1:0]   prod_q;
   logic [2*DW-1:0]   prod_s;
   logic [ACCW:0]     sum_s;
   logic [ACCW-1:0]   acc_q, acc_d;
   logic              ov_q, rdy_q, busy_q, done_q;

   // rdy_q is a registered copy of (state == RUN), so it doubles as the accept qualifier
   assign accept_s = in_valid && rdy_q;
   assign prod_s   = (2*DW)'(a_q) * (2*DW)'(b_q);
   assign sum_s    = {1'b0, acc_q} + {{(ACCW+1-2*DW){1'b0}}, prod_q};

   // Next-state logic: frame sequencing, sample counting and drain timing
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      drain_d   = drain_q;
      sat_d     = sat_q;
      clr_acc_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               clr_acc_s = 1'b1;
               if (len != {CW{1'b0}}) begin
                  cnt_d   = len;
                  sat_d   = sat_en;
                  state_d = S_RUN;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (accept_s) begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
               if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                  drain_d = 1'b0;
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         // two cycles let the last sample's product reach the accumulator
         S_DRAIN: begin
            if (drain_q) begin
               state_d = S_DONE;
            end else begin
               drain_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Accumulator update: clear on frame start, otherwise wrap or clamp per latched mode
   always_comb begin
      acc_d = acc_q;
      if (clr_acc_s) begin
         acc_d = {ACCW{1'b0}};
      end else if (v2_q) begin
         if (sat_q && sum_s[ACCW]) begin
            acc_d = {ACCW{1'b1}};
         end else begin
            acc_d = sum_s[ACCW-1:0];
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Control state and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         drain_q <= 1'b0;
         sat_q   <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         sat_q   <= sat_d;
         rdy_q   <= (state_d == S_RUN);
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   // Datapath pipeline: operands, product, accumulator
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q    <= {DW{1'b0}};
         b_q    <= {DW{1'b0}};
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         prod_q <= {(2*DW){1'b0}};
         acc_q  <= {ACCW{1'b0}};
         ov_q   <= 1'b0;
      end else begin
         v1_q <= accept_s;
         if (accept_s) begin
            a_q <= a;
            b_q <= b;
         end
         v2_q <= v1_q;
         if (v1_q) begin
            prod_q <= prod_s;
         end
         acc_q <= acc_d;
         ov_q  <= v2_q;
      end
   end

   assign in_ready  = rdy_q;
   assign prod      = prod_q;
   assign acc       = acc_q;
   assign out_valid = ov_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mac_frame_pipe.sv
// Bench for mac_frame_pipe: a transaction-level latency model checked every cycle,
// plus literal frame results (including a 16-bit accumulator instance for saturation/wrap).
module tb_mac_frame_pipe;
   localparam int DW   = 8;
   localparam int CW   = 6;
   localparam int ACCW = 20;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, sat_en = 1'b0, in_valid = 1'b0;
   logic [CW-1:0] len = '0;
   logic [DW-1:0] a = '0, b = '0;
   logic in_ready, out_valid, busy, done;
   logic [2*DW-1:0] prod;
   logic [ACCW-1:0] acc;
   logic in_ready16, out_valid16, busy16, done16;
   logic [2*DW-1:0] prod16;
   logic [15:0] acc16;

   mac_frame_pipe #(.DW(DW), .CW(CW), .ACCW(ACCW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .sat_en(sat_en), .in_valid(in_valid),
      .a(a), .b(b), .in_ready(in_ready), .prod(prod), .acc(acc), .out_valid(out_valid),
      .busy(busy), .done(done));

   mac_frame_pipe #(.DW(DW), .CW(CW), .ACCW(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start), .len(len), .sat_en(sat_en), .in_valid(in_valid),
      .a(a), .b(b), .in_ready(in_ready16), .prod(prod16), .acc(acc16), .out_valid(out_valid16),
      .busy(busy16), .done(done16));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: frame events scheduled by their latency ----------------
   int     cyc = 0;
   bit     frame_open;
   int     rem, done_at;
   bit     m_sat, ov_now;
   longint m_sum, m_acc, m_prod;
   int     pq_due[$], sq_due[$];
   longint pq_val[$], sq_val[$];
   localparam longint ACC_MAX = (64'sd1 <<< ACCW) - 64'sd1;

   task automatic reset_model();
      frame_open = 1'b0; rem = 0; done_at = -1; m_sat = 1'b0; ov_now = 1'b0;
      m_sum = 0; m_acc = 0; m_prod = 0;
      pq_due.delete(); pq_val.delete(); sq_due.delete(); sq_val.delete();
   endtask

   task automatic step_model();
      bit busy_now, take;
      longint p;
      busy_now = frame_open || (cyc <= done_at);
      take     = frame_open && in_valid;
      cyc++;
      ov_now = 1'b0;
      if (start && !busy_now) begin
         m_acc = 0;
         m_sum = 0;
         if (len == 0) begin
            done_at = cyc;
         end else begin
            frame_open = 1'b1;
            rem        = int'(len);
            m_sat      = sat_en;
         end
      end else if (take) begin
         p     = longint'(a) * longint'(b);
         m_sum = m_sum + p;
         if (m_sat) m_sum = (m_sum > ACC_MAX) ? ACC_MAX : m_sum;
         else       m_sum = m_sum % (ACC_MAX + 1);
         pq_due.push_back(cyc + 1); pq_val.push_back(p);
         sq_due.push_back(cyc + 2); sq_val.push_back(m_sum);
         rem--;
         if (rem == 0) begin
            frame_open = 1'b0;
            done_at    = cyc + 2;
         end
      end
      if (pq_due.size() > 0 && pq_due[0] == cyc) begin
         m_prod = pq_val.pop_front();
         void'(pq_due.pop_front());
      end
      if (sq_due.size() > 0 && sq_due[0] == cyc) begin
         m_acc  = sq_val.pop_front();
         void'(sq_due.pop_front());
         ov_now = 1'b1;
      end
   endtask

   initial begin
      reset_model();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) reset_model();
         else      step_model();
      end
   end

   // ---------------- per-cycle compare and result capture ----------------
   int     done_cnt = 0, ready_seen = 0, done_cyc = 0;
   longint done_acc = 0, done_acc16 = 0;
   longint ov_log[$];

   always @(negedge clk) begin
      if (rst) begin
         chk("in_ready",  in_ready,  frame_open);
         chk("busy",      busy,      frame_open || (cyc <= done_at));
         chk("done",      done,      cyc == done_at);
         chk("out_valid", out_valid, ov_now);
         chk("acc",       acc,       m_acc);
         chk("prod",      prod,      m_prod);
         if (in_ready)  ready_seen++;
         if (out_valid) ov_log.push_back(longint'(acc));
         if (done) begin
            done_cnt++;
            done_acc   = longint'(acc);
            done_acc16 = longint'(acc16);
            done_cyc   = cyc;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one frame; returns the start-edge-to-done latency in cycles.
   task automatic frame(input logic [CW-1:0] l, input bit sat, input logic [DW-1:0] aa,
                        input logic [DW-1:0] bb, input bit toggle, input int restart_at,
                        output int lat);
      int d0, st;
      d0 = done_cnt;
      st = cyc + 1;
      start = 1'b1; len = l; sat_en = sat; a = aa; b = bb; in_valid = 1'b1;
      tick();
      start = 1'b0; len = 6'd63; sat_en = ~sat;
      for (int i = 0; i < 100 && done_cnt == d0; i++) begin
         if (toggle) in_valid = ~in_valid;
         if (i == restart_at) begin
            start = 1'b1; len = 6'd9; sat_en = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0; in_valid = 1'b0;
      chk("done_seen", done_cnt - d0, 1);
      lat = done_cyc - st;
      for (int i = 0; i < 4; i++) tick();
      chk("done_once", done_cnt - d0, 1);
   endtask

   int lat, r0, d0;

   initial begin
      #2 rst = 1'b0;
      tick(); tick();
      chk("rst_acc", acc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_done", done, 0);
      rst = 1'b1;
      tick(); tick();

      // plain frame: 5*7 accumulated four times
      ov_log.delete();
      frame(6'd4, 1'b0, 8'd5, 8'd7, 1'b0, -1, lat);
      chk("t1_ov_count", ov_log.size(), 4);
      if (ov_log.size() == 4) begin
         chk("t1_ov0", ov_log[0], 35);
         chk("t1_ov1", ov_log[1], 70);
         chk("t1_ov2", ov_log[2], 105);
         chk("t1_ov3", ov_log[3], 140);
      end
      chk("t1_done_acc", done_acc, 140);
      chk("t1_latency", lat, 6);

      // bubbles every other cycle: same sum, done four cycles later
      ov_log.delete();
      frame(6'd4, 1'b0, 8'd5, 8'd7, 1'b1, -1, lat);
      chk("t2_ov_count", ov_log.size(), 4);
      chk("t2_done_acc", done_acc, 140);
      chk("t2_latency", lat, 10);

      // empty frame
      ov_log.delete();
      r0 = ready_seen;
      frame(6'd0, 1'b0, 8'd9, 8'd9, 1'b0, -1, lat);
      chk("t3_no_ready", ready_seen - r0, 0);
      chk("t3_ov_count", ov_log.size(), 0);
      chk("t3_done_acc", done_acc, 0);
      chk("t3_latency", lat, 0);

      // saturate vs wrap on the 16-bit instance (sat_en flipped after start)
      frame(6'd2, 1'b1, 8'd255, 8'd255, 1'b0, -1, lat);
      chk("t4_sat16", done_acc16, 65535);
      chk("t4_sat20", done_acc, 130050);
      frame(6'd2, 1'b0, 8'd255, 8'd255, 1'b0, -1, lat);
      chk("t4_wrap16", done_acc16, 64514);
      chk("t4_wrap20", done_acc, 130050);

      // second start while running is ignored
      ov_log.delete();
      frame(6'd4, 1'b0, 8'd5, 8'd7, 1'b0, 1, lat);
      chk("t5_ov_count", ov_log.size(), 4);
      chk("t5_done_acc", done_acc, 140);

      // asynchronous reset mid-frame
      d0 = done_cnt;
      start = 1'b1; len = 6'd4; a = 8'd5; b = 8'd7; in_valid = 1'b1; sat_en = 1'b0;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      #1 rst = 1'b0;
      #1;
      chk("t6_acc_async", acc, 0);
      chk("t6_busy_async", busy, 0);
      chk("t6_ready_async", in_ready, 0);
      chk("t6_ov_async", out_valid, 0);
      chk("t6_prod_async", prod, 0);
      tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      in_valid = 1'b0;
      chk("t6_no_done", done_cnt - d0, 0);
      frame(6'd1, 1'b0, 8'd3, 8'd4, 1'b0, -1, lat);
      chk("t6_after_rst", done_acc, 12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
